arbitro_cuatro: RTL and testbench

Round-robin arbiter that shares one 4-input datapath resource among four requesters. It drives the 2-bit select of the downstream 4:1 bus multiplexer and a one-hot grant back to the requesters. A grant is held until the owner signals completion, the owner drops its request, or a hold timeout expires. It sits between the requesting pipeline units and the shared mux and resource in the MIPS datapath.

---
 rtl/arbitro_cuatro_if.sv | 30 +++
 rtl/arbitro_cuatro.sv | 149 ++++++++++++++
 tb/tb_arbitro_cuatro.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_cuatro_if.sv
// Request/grant bundle between the four requesting pipeline units and the
// round-robin arbiter that steers the shared 4:1 datapath mux.
interface arbitro_cuatro_if;
    logic [3:0] i_Request;
    logic       i_Done;
    logic [3:0] o_Grant;
    logic [1:0] o_Control;
    logic       o_Valid;
    logic       o_Timeout;

    // Arbiter side: consumes requests and completion, produces grant and select
    modport slave (
        input  i_Request,
        input  i_Done,
        output o_Grant,
        output o_Control,
        output o_Valid,
        output o_Timeout
    );

    // Requester / resource side: produces requests and completion
    modport master (
        output i_Request,
        output i_Done,
        input  o_Grant,
        input  o_Control,
        input  o_Valid,
        input  o_Timeout
    );
endinterface

// File: rtl/arbitro_cuatro.sv
// Four-way round-robin arbiter for the shared datapath resource.
// One owner at a time; ownership ends on completion, on the owner dropping
// its request, or when the hold budget runs out. On release the next owner
// is chosen in the same edge (released owner excluded), so a busy bus never
// sees an idle cycle. All outputs come straight from flops.
module arbitro_cuatro #(
    parameter int HOLD_WIDTH = 4,
    parameter int MAX_HOLD   = 15
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    arbitro_cuatro_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Counter value seen on the last permitted cycle of a grant
    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(MAX_HOLD - 1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_ONE  = HOLD_WIDTH'(1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_ZERO = HOLD_WIDTH'(0);

    // Index to one-hot for the grant vector
    function automatic logic [3:0] to_onehot(input logic [1:0] idx);
        logic [3:0] base;
        base = 4'b0001;
        return base << idx;
    endfunction

    // Round-robin search starting at ptr; returns {found, index}.
    // Walks from the lowest priority to the highest so the last hit
    // (the one nearest ptr) is what remains.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_t                  state_q;
    logic [3:0]              grant_q;
    logic [1:0]              control_q;
    logic                    valid_q;
    logic                    timeout_q;
    logic [1:0]              ptr_q;
    logic [HOLD_WIDTH-1:0]   cnt_q;

    logic                    rel_done_s;
    logic                    rel_abort_s;
    logic                    at_limit_s;
    logic                    release_s;
    logic                    rel_timeout_s;
    logic [1:0]              ptr_d;
    logic [3:0]              masked_req_s;
    logic [2:0]              idle_pick_s;
    logic [2:0]              rel_pick_s;

    // Release conditions and both arbitration candidates (fresh and hand-over)
    always_comb begin
        rel_done_s    = bus.i_Done;
        // the owner is the set bit of grant_q, so its request is req & grant
        rel_abort_s   = ~|(bus.i_Request & grant_q);
        at_limit_s    = (cnt_q == HOLD_LAST);
        release_s     = rel_done_s | rel_abort_s | at_limit_s;
        // done and abort take precedence over the hold limit
        rel_timeout_s = at_limit_s & ~rel_done_s & ~rel_abort_s;
        // control_q always holds the current owner while in GRANT
        ptr_d         = control_q + 2'd1;
        masked_req_s  = bus.i_Request & ~grant_q;
        idle_pick_s   = rr_pick(bus.i_Request, ptr_q);
        rel_pick_s    = rr_pick(masked_req_s, ptr_d);
    end

    // Arbitration FSM with registered grant, select, valid and timeout outputs
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= 4'b0000;
            control_q <= 2'b00;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= 2'b00;
            cnt_q     <= HOLD_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    timeout_q <= 1'b0;
                    if (idle_pick_s[2]) begin
                        grant_q   <= to_onehot(idle_pick_s[1:0]);
                        control_q <= idle_pick_s[1:0];
                        valid_q   <= 1'b1;
                        cnt_q     <= HOLD_ZERO;
                        state_q   <= ST_GRANT;
                    end else begin
                        // select keeps its last value so the mux does not toggle
                        grant_q   <= 4'b0000;
                        valid_q   <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (release_s) begin
                        ptr_q     <= ptr_d;
                        timeout_q <= rel_timeout_s;
                        if (rel_pick_s[2]) begin
                            grant_q   <= to_onehot(rel_pick_s[1:0]);
                            control_q <= rel_pick_s[1:0];
                            valid_q   <= 1'b1;
                            cnt_q     <= HOLD_ZERO;
                        end else begin
                            grant_q   <= 4'b0000;
                            valid_q   <= 1'b0;
                            state_q   <= ST_IDLE;
                        end
                    end else begin
                        timeout_q <= 1'b0;
                        if (cnt_q != HOLD_LAST) begin
                            cnt_q <= cnt_q + HOLD_ONE;
                        end else begin
                            cnt_q <= cnt_q;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    grant_q   <= 4'b0000;
                    valid_q   <= 1'b0;
                    timeout_q <= 1'b0;
                    cnt_q     <= HOLD_ZERO;
                end
            endcase
        end
    end

    assign bus.o_Grant   = grant_q;
    assign bus.o_Control = control_q;
    assign bus.o_Valid   = valid_q;
    assign bus.o_Timeout = timeout_q;

endmodule

// File: tb/tb_arbitro_cuatro.sv
// Bench for arbitro_cuatro: directed vector table, hand sequences for reset,
// timeout and coincidence, then random traffic against a behavioural model.
module tb_arbitro_cuatro;

    localparam int HOLD_WIDTH = 4;
    localparam int MAX_HOLD   = 15;

    logic i_Clock;
    logic i_Reset;

    arbitro_cuatro_if iface ();

    arbitro_cuatro #(
        .HOLD_WIDTH (HOLD_WIDTH),
        .MAX_HOLD   (MAX_HOLD)
    ) dut (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .bus     (iface.slave)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    int tests;
    int failed;

    // Behavioural model: owner index (-1 = nobody), pointer, cycles the
    // grant has been visible, last select, timeout flag.
    int m_owner;
    int m_ptr;
    int m_held;
    int m_ctrl;
    bit m_to;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] grant;
        logic [1:0] ctrl;
        logic       valid;
        logic       tmo;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int search(input logic [3:0] r, input int p, input int skip);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (p + k) % 4;
            if (idx != skip && r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_ctrl  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] req, input logic done);
        int w;
        int prev;
        bit to;
        to = 1'b0;
        if (m_owner < 0) begin
            w = search(req, m_ptr, -1);
            if (w >= 0) begin
                m_owner = w;
                m_ctrl  = w;
                m_held  = 1;
            end
        end else if (done || !req[m_owner] || m_held >= MAX_HOLD) begin
            to     = (m_held >= MAX_HOLD) && !done && req[m_owner];
            prev   = m_owner;
            m_ptr  = (prev + 1) % 4;
            w      = search(req, m_ptr, prev);
            if (w >= 0) begin
                m_owner = w;
                m_ctrl  = w;
                m_held  = 1;
            end else begin
                m_owner = -1;
            end
        end else begin
            m_held++;
        end
        m_to = to;
    endtask

    function automatic logic [3:0] m_grant();
        logic [3:0] one;
        one = 4'b0001;
        return (m_owner < 0) ? 4'b0000 : (one << m_owner);
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".grant"},   {4'b0000, iface.o_Grant},   {4'b0000, m_grant()});
        chk({tag, ".control"}, {6'b000000, iface.o_Control}, 8'(m_ctrl));
        chk({tag, ".valid"},   {7'b0000000, iface.o_Valid}, {7'b0000000, (m_owner >= 0)});
        chk({tag, ".timeout"}, {7'b0000000, iface.o_Timeout}, {7'b0000000, m_to});
    endtask

    // One clock: drive on the falling edge, advance the model on the rising
    // edge, compare 1 time unit later.
    task automatic step(input logic [3:0] req, input logic done, input string tag);
        @(negedge i_Clock);
        iface.i_Request = req;
        iface.i_Done    = done;
        @(posedge i_Clock);
        model_step(req, done);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        @(negedge i_Clock);
        i_Reset         = 1'b1;
        iface.i_Request = 4'b0000;
        iface.i_Done    = 1'b0;
        model_reset();
        @(negedge i_Clock);
        i_Reset = 1'b0;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        i_Reset         = 1'b1;
        iface.i_Request = 4'b0000;
        iface.i_Done    = 1'b0;
        model_reset();

        // Directed table, starting from reset (ptr = 0)
        tbl[0]  = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[1]  = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[2]  = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[3]  = '{4'b0010, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
        tbl[4]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[5]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[8]  = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[9]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[10] = '{4'b1001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[11] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[12] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[13] = '{4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[14] = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[15] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};

        // Reset values
        repeat (2) @(posedge i_Clock);
        #1;
        chk("rst.grant",   {4'b0000, iface.o_Grant},     8'h00);
        chk("rst.control", {6'b000000, iface.o_Control}, 8'h00);
        chk("rst.valid",   {7'b0000000, iface.o_Valid},  8'h00);
        chk("rst.timeout", {7'b0000000, iface.o_Timeout}, 8'h00);
        @(negedge i_Clock);
        i_Reset = 1'b0;

        // Table vectors
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].req, tbl[i].done, "tbl");
            chk($sformatf("tbl%0d.grant", i),   {4'b0000, iface.o_Grant},       {4'b0000, tbl[i].grant});
            chk($sformatf("tbl%0d.control", i), {6'b000000, iface.o_Control},   {6'b000000, tbl[i].ctrl});
            chk($sformatf("tbl%0d.valid", i),   {7'b0000000, iface.o_Valid},    {7'b0000000, tbl[i].valid});
            chk($sformatf("tbl%0d.timeout", i), {7'b0000000, iface.o_Timeout},  {7'b0000000, tbl[i].tmo});
        end

        // Asynchronous reset in the middle of a grant
        do_reset();
        step(4'b1000, 1'b0, "pre_arst");
        step(4'b0100, 1'b1, "pre_arst");
        #2;
        i_Reset = 1'b1;
        #1;
        chk("arst.grant",   {4'b0000, iface.o_Grant},     8'h00);
        chk("arst.control", {6'b000000, iface.o_Control}, 8'h00);
        chk("arst.valid",   {7'b0000000, iface.o_Valid},  8'h00);
        model_reset();
        @(negedge i_Clock);
        i_Reset = 1'b0;
        step(4'b0100, 1'b0, "post_arst");
        chk("post_arst.grant", {4'b0000, iface.o_Grant},     8'h04);
        chk("post_arst.ctrl",  {6'b000000, iface.o_Control}, 8'h02);

        // Hold timeout: grant visible for MAX_HOLD cycles, then a one-cycle pulse
        do_reset();
        step(4'b0001, 1'b0, "to_grant");
        for (int c = 1; c < MAX_HOLD; c++) begin
            step(4'b0001, 1'b0, "to_hold");
            chk("to_hold.grant", {4'b0000, iface.o_Grant}, 8'h01);
        end
        step(4'b0001, 1'b0, "to_fire");
        chk("to_fire.timeout", {7'b0000000, iface.o_Timeout}, 8'h01);
        chk("to_fire.grant",   {4'b0000, iface.o_Grant},      8'h00);
        step(4'b0001, 1'b0, "to_regrant");
        chk("to_regrant.timeout", {7'b0000000, iface.o_Timeout}, 8'h00);
        chk("to_regrant.grant",   {4'b0000, iface.o_Grant},      8'h01);

        // Done coinciding with the timeout cycle: no pulse
        for (int c = 1; c < MAX_HOLD; c++) begin
            step(4'b0001, 1'b0, "co_hold");
        end
        step(4'b0001, 1'b1, "co_done");
        chk("co_done.timeout", {7'b0000000, iface.o_Timeout}, 8'h00);
        chk("co_done.grant",   {4'b0000, iface.o_Grant},      8'h00);

        // Abort coinciding with the timeout cycle, hand over to requester 2
        step(4'b0010, 1'b0, "ab_grant");
        for (int c = 1; c < MAX_HOLD; c++) begin
            step(4'b0010, 1'b0, "ab_hold");
        end
        step(4'b0100, 1'b0, "ab_drop");
        chk("ab_drop.timeout", {7'b0000000, iface.o_Timeout}, 8'h00);
        chk("ab_drop.grant",   {4'b0000, iface.o_Grant},      8'h04);

        // Random traffic against the model; requests often persist so that
        // long holds and timeouts appear
        begin
            logic [3:0] req;
            logic       done;
            req = 4'b0000;
            for (int n = 0; n < 600; n++) begin
                if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
                done = ($urandom_range(0, 9) == 0);
                step(req, done, "rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
